// File: rtl/yari_mem_pkg.sv
// Shared definitions for the yari memory-side path: requester tags,
// controller state encoding and small helpers.
package yari_mem_pkg;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_DC   = 2'd1;
    localparam logic [1:0] ID_IC   = 2'd2;

    // Wide enough for WAIT_STATES up to 15 and WR_RECOVERY up to 3
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    function automatic logic [3:0] mask_to_be_n(input logic [3:0] mask);
        return ~mask;
    endfunction

endpackage

// File: rtl/yari_sram_ctrl.sv
// Single-request asynchronous SRAM controller behind the yari unified memory
// port: tagged word reads/writes with programmable wait states and write recovery.
module yari_sram_ctrl
    import yari_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned WR_RECOVERY = 1,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clock,
    input  logic              rst,

    output logic              mem_waitrequest,
    input  logic [1:0]        mem_id,
    input  logic [29:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_writedata,
    input  logic [3:0]        mem_writedatamask,
    output logic [31:0]       mem_readdata,
    output logic [1:0]        mem_readdataid,

    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_d_o,
    output logic              sram_d_oe,
    input  logic [31:0]       sram_d_i,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] REC_LOAD  =
        (WR_RECOVERY == 0) ? '0 : CNT_W'(WR_RECOVERY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         id_q, id_d;

    logic               waitreq_d;
    logic [31:0]        rdata_d;
    logic [1:0]         rid_d;
    logic [ADDR_W-1:0]  a_d;
    logic [31:0]        d_o_d;
    logic               d_oe_d;
    logic [3:0]         be_n_d;
    logic               ce_n_d;
    logic               oe_n_d;
    logic               we_n_d;

    // Upper address bits are deliberately ignored so the SRAM aliases
    if (ADDR_W < 30) begin : g_addr_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_address[29:ADDR_W];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        waitreq_d = mem_waitrequest;
        rdata_d   = mem_readdata;
        rid_d     = ID_NONE;
        a_d       = sram_a;
        d_o_d     = sram_d_o;
        d_oe_d    = sram_d_oe;
        be_n_d    = sram_be_n;
        ce_n_d    = sram_ce_n;
        oe_n_d    = sram_oe_n;
        we_n_d    = sram_we_n;

        case (state_q)
            ST_IDLE: begin
                if (!mem_waitrequest && (mem_read || mem_write)) begin
                    waitreq_d = 1'b1;
                    a_d       = mem_address[ADDR_W-1:0];
                    cnt_d     = WAIT_LOAD;
                    ce_n_d    = 1'b0;
                    // A write strobe wins over a simultaneous read strobe
                    if (mem_write) begin
                        state_d = ST_WRITE;
                        d_o_d   = mem_writedata;
                        d_oe_d  = 1'b1;
                        be_n_d  = mask_to_be_n(mem_writedatamask);
                        oe_n_d  = 1'b1;
                        we_n_d  = 1'b0;
                    end else begin
                        state_d = ST_READ;
                        id_d    = mem_id;
                        d_oe_d  = 1'b0;
                        be_n_d  = '0;
                        oe_n_d  = 1'b0;
                        we_n_d  = 1'b1;
                    end
                end else begin
                    waitreq_d = 1'b0;
                end
            end

            ST_READ: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    rdata_d   = sram_d_i;
                    rid_d     = id_q;
                    waitreq_d = 1'b0;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    be_n_d    = '1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_WRITE: begin
                if (cnt_q == '0) begin
                    we_n_d = 1'b1;
                    if (WR_RECOVERY == 0) begin
                        state_d   = ST_IDLE;
                        waitreq_d = 1'b0;
                        ce_n_d    = 1'b1;
                        d_oe_d    = 1'b0;
                        be_n_d    = '1;
                    end else begin
                        // Data, address and byte enables stay driven through recovery
                        state_d = ST_RECOVER;
                        cnt_d   = REC_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    waitreq_d = 1'b0;
                    ce_n_d    = 1'b1;
                    d_oe_d    = 1'b0;
                    be_n_d    = '1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                waitreq_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            id_q            <= ID_NONE;
            mem_waitrequest <= 1'b1;
            mem_readdata    <= '0;
            mem_readdataid  <= ID_NONE;
            sram_a          <= '0;
            sram_d_o        <= '0;
            sram_d_oe       <= 1'b0;
            sram_be_n       <= '1;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            id_q            <= id_d;
            mem_waitrequest <= waitreq_d;
            mem_readdata    <= rdata_d;
            mem_readdataid  <= rid_d;
            sram_a          <= a_d;
            sram_d_o        <= d_o_d;
            sram_d_oe       <= d_oe_d;
            sram_be_n       <= be_n_d;
            sram_ce_n       <= ce_n_d;
            sram_oe_n       <= oe_n_d;
            sram_we_n       <= we_n_d;
        end
    end

endmodule

// File: tb/tb_yari_sram_ctrl.sv
// Directed bench for yari_sram_ctrl: one instance at W=2/R=1, one at W=0/R=0,
// with a read-return scoreboard per instance.
module tb_yari_sram_ctrl;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;

    // instance with W=2, R=1
    logic        rd, wr, waitreq, d_oe, ce_n, oe_n, we_n;
    logic [31:0] rdata, d_o, d_i;
    logic [1:0]  rid;
    logic [17:0] a;
    logic [3:0]  be_n;

    // instance with W=0, R=0
    logic        rd0, wr0, waitreq0, d_oe0, ce_n0, oe_n0, we_n0;
    logic [31:0] rdata0, d_o0, d_i0;
    logic [1:0]  rid0;
    logic [17:0] a0;
    logic [3:0]  be_n0;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    exp_t q[$];
    exp_t q0[$];

    always #5 clock = ~clock;

    // Simple SRAM model for the zero-wait instance: data derived from address
    assign d_i0 = 32'hA500_0000 | 32'(a0);

    yari_sram_ctrl #(.WAIT_STATES(2), .WR_RECOVERY(1), .ADDR_W(18)) dut (
        .clock(clock), .rst(rst),
        .mem_waitrequest(waitreq), .mem_id(mem_id), .mem_address(mem_address),
        .mem_read(rd), .mem_write(wr), .mem_writedata(mem_writedata),
        .mem_writedatamask(mem_writedatamask),
        .mem_readdata(rdata), .mem_readdataid(rid),
        .sram_a(a), .sram_d_o(d_o), .sram_d_oe(d_oe), .sram_d_i(d_i),
        .sram_be_n(be_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
    );

    yari_sram_ctrl #(.WAIT_STATES(0), .WR_RECOVERY(0), .ADDR_W(18)) dut0 (
        .clock(clock), .rst(rst),
        .mem_waitrequest(waitreq0), .mem_id(mem_id), .mem_address(mem_address),
        .mem_read(rd0), .mem_write(wr0), .mem_writedata(mem_writedata),
        .mem_writedatamask(mem_writedatamask),
        .mem_readdata(rdata0), .mem_readdataid(rid0),
        .sram_a(a0), .sram_d_o(d_o0), .sram_d_oe(d_oe0), .sram_d_i(d_i0),
        .sram_be_n(be_n0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Scoreboards: every tagged return must match the oldest outstanding read
    always @(negedge clock) begin
        exp_t e;
        if (rid != 2'd0) begin
            if (q.size() == 0) chk("unexpected_rid", 32'(rid), 32'd0);
            else begin
                e = q.pop_front();
                chk("sb_rid", 32'(rid), 32'(e.id));
                chk("sb_rdata", rdata, e.data);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (rid0 != 2'd0) begin
            if (q0.size() == 0) chk("unexpected_rid0", 32'(rid0), 32'd0);
            else begin
                e = q0.pop_front();
                chk("sb0_rid", 32'(rid0), 32'(e.id));
                chk("sb0_rdata", rdata0, e.data);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_waitreq"}, 32'(waitreq), 32'd1);
        chk({tag, "_rid"},     32'(rid),     32'd0);
        chk({tag, "_rdata"},   rdata,        32'd0);
        chk({tag, "_ce_n"},    32'(ce_n),    32'd1);
        chk({tag, "_oe_n"},    32'(oe_n),    32'd1);
        chk({tag, "_we_n"},    32'(we_n),    32'd1);
        chk({tag, "_be_n"},    32'(be_n),    32'hF);
        chk({tag, "_d_oe"},    32'(d_oe),    32'd0);
        chk({tag, "_a"},       32'(a),       32'd0);
        chk({tag, "_d_o"},     d_o,          32'd0);
    endtask

    initial begin
        rst = 1'b0;
        rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        mem_id = 2'd0; mem_address = '0; mem_writedata = '0; mem_writedatamask = '0;
        d_i = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_reset_vals("reset");
        end
        rst = 1'b1;
        cyc();
        chk("rel_waitreq", 32'(waitreq), 32'd0);
        chk("rel_waitreq0", 32'(waitreq0), 32'd0);

        // Read, id 1, aliased upper address bits, data only valid at the sample edge
        rd = 1'b1; mem_id = 2'd1; mem_address = 30'h2AC0_0123; d_i = 32'h0BAD_0BAD;
        q.push_back('{id: 2'd1, data: 32'hDEAD_BEEF});
        cyc();
        rd = 1'b0;
        chk("rd_a", 32'(a), 32'h0_0123);
        chk("rd_ce_n", 32'(ce_n), 32'd0);
        chk("rd_we_n", 32'(we_n), 32'd1);
        chk("rd_be_n", 32'(be_n), 32'h0);
        chk("rd_d_oe", 32'(d_oe), 32'd0);
        chk("rd_waitreq", 32'(waitreq), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) cyc();
            chk("rd_oe_n_low", 32'(oe_n), 32'd0);
            chk("rd_rid_quiet", 32'(rid), 32'd0);
        end
        d_i = 32'hDEAD_BEEF;
        cyc();
        d_i = 32'hBADB_AD00;
        chk("rd_rid", 32'(rid), 32'd1);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd_oe_n_rel", 32'(oe_n), 32'd1);
        chk("rd_waitreq_rel", 32'(waitreq), 32'd0);
        cyc();
        chk("rd_rid_once", 32'(rid), 32'd0);
        chk("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Write, mask 0101, one recovery cycle, next acceptance at t+5
        chk("wr_ready", 32'(waitreq), 32'd0);
        wr = 1'b1; mem_id = 2'd1; mem_address = 30'h456;
        mem_writedata = 32'h1122_3344; mem_writedatamask = 4'b0101;
        cyc();
        wr = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) cyc();
            chk("wr_we_n_low", 32'(we_n), 32'd0);
            chk("wr_ce_n", 32'(ce_n), 32'd0);
            chk("wr_oe_n", 32'(oe_n), 32'd1);
            chk("wr_d_oe", 32'(d_oe), 32'd1);
            chk("wr_be_n", 32'(be_n), 32'hA);
            chk("wr_d_o", d_o, 32'h1122_3344);
            chk("wr_a", 32'(a), 32'h456);
            chk("wr_waitreq", 32'(waitreq), 32'd1);
        end
        cyc();
        chk("rec_we_n", 32'(we_n), 32'd1);
        chk("rec_ce_n", 32'(ce_n), 32'd0);
        chk("rec_d_oe", 32'(d_oe), 32'd1);
        chk("rec_d_o", d_o, 32'h1122_3344);
        chk("rec_be_n", 32'(be_n), 32'hA);
        chk("rec_a", 32'(a), 32'h456);
        chk("rec_waitreq", 32'(waitreq), 32'd1);
        cyc();
        chk("wr_done_waitreq", 32'(waitreq), 32'd0);
        chk("wr_done_ce_n", 32'(ce_n), 32'd1);
        chk("wr_done_d_oe", 32'(d_oe), 32'd0);

        // Read id 2 issued immediately after the write
        rd = 1'b1; mem_id = 2'd2; mem_address = 30'h789; d_i = 32'hCAFE_F00D;
        q.push_back('{id: 2'd2, data: 32'hCAFE_F00D});
        cyc();
        rd = 1'b0;
        chk("rd2_oe_n", 32'(oe_n), 32'd0);
        chk("rd2_a", 32'(a), 32'h789);
        cyc(); cyc(); cyc();
        chk("rd2_rid", 32'(rid), 32'd2);

        // Simultaneous read and write strobes: write only, no return
        rd = 1'b1; wr = 1'b1; mem_id = 2'd1; mem_address = 30'h0AB;
        mem_writedata = 32'h55AA_55AA; mem_writedatamask = 4'b1111;
        cyc();
        rd = 1'b0; wr = 1'b0;
        chk("rw_we_n", 32'(we_n), 32'd0);
        chk("rw_oe_n", 32'(oe_n), 32'd1);
        chk("rw_be_n", 32'(be_n), 32'h0);
        chk("rw_d_o", d_o, 32'h55AA_55AA);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rw_no_rid", 32'(rid), 32'd0);
        end
        chk("rw_done_waitreq", 32'(waitreq), 32'd0);

        // Reset asserted while a read is in flight
        rd = 1'b1; mem_id = 2'd1; mem_address = 30'h333; d_i = 32'h1234_5678;
        cyc();
        rd = 1'b0;
        chk("abort_oe_n", 32'(oe_n), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk_reset_vals("abort");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_no_rid", 32'(rid), 32'd0);
        end
        chk("abort_waitreq", 32'(waitreq), 32'd0);

        // Zero-wait instance: back-to-back reads id 2, request held across waitrequest
        rd0 = 1'b1; mem_id = 2'd2; mem_address = 30'h10;
        q0.push_back('{id: 2'd2, data: 32'hA500_0010});
        cyc();
        mem_address = 30'h11;
        q0.push_back('{id: 2'd2, data: 32'hA500_0011});
        chk("b2b_waitreq1", 32'(waitreq0), 32'd1);
        chk("b2b_a1", 32'(a0), 32'h10);
        chk("b2b_oe_n1", 32'(oe_n0), 32'd0);
        cyc();
        chk("b2b_rid1", 32'(rid0), 32'd2);
        chk("b2b_waitreq_free", 32'(waitreq0), 32'd0);
        cyc();
        rd0 = 1'b0;
        chk("b2b_gap", 32'(rid0), 32'd0);
        chk("b2b_a2", 32'(a0), 32'h11);
        cyc();
        chk("b2b_rid2", 32'(rid0), 32'd2);
        chk("b2b_rdata2", rdata0, 32'hA500_0011);
        cyc();
        chk("b2b_rid_end", 32'(rid0), 32'd0);

        // Zero-wait, zero-recovery write with empty mask
        wr0 = 1'b1; mem_address = 30'h20; mem_writedata = 32'h0F0F_0F0F; mem_writedatamask = 4'b0000;
        cyc();
        wr0 = 1'b0;
        chk("w0_we_n", 32'(we_n0), 32'd0);
        chk("w0_be_n", 32'(be_n0), 32'hF);
        chk("w0_d_oe", 32'(d_oe0), 32'd1);
        chk("w0_d_o", d_o0, 32'h0F0F_0F0F);
        cyc();
        chk("w0_we_n_rel", 32'(we_n0), 32'd1);
        chk("w0_d_oe_rel", 32'(d_oe0), 32'd0);
        chk("w0_ce_n_rel", 32'(ce_n0), 32'd1);
        chk("w0_waitreq", 32'(waitreq0), 32'd0);

        repeat (3) cyc();
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("sb0_drained", 32'(q0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
